// File: rtl/axil_apb_master.sv
// axil_apb_master: AXI4-Lite slave to APB master bridge, one transaction in flight, round-robin read/write arbitration
module axil_apb_master #(
  parameter int dataWidth = 32,
  parameter int addrWidth = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [addrWidth-1:0]   awaddr,
  input  logic [2:0]             awprot,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [dataWidth-1:0]   wdata,
  input  logic [dataWidth/8-1:0] wstrb,
  output logic                   bvalid,
  input  logic                   bready,
  output logic [1:0]             bresp,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [addrWidth-1:0]   araddr,
  input  logic [2:0]             arprot,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [dataWidth-1:0]   rdata,
  output logic [1:0]             rresp,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [addrWidth-1:0]   paddr,
  output logic [2:0]             pprot,
  output logic [dataWidth-1:0]   pwdata,
  output logic [dataWidth/8-1:0] pstrb,
  input  logic                   pready,
  input  logic [dataWidth-1:0]   prdata,
  input  logic                   pslverr
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WDATA  = 3'd1;
  localparam logic [2:0] SETUP  = 3'd2;
  localparam logic [2:0] ACCESS = 3'd3;
  localparam logic [2:0] BRESP  = 3'd4;
  localparam logic [2:0] RRESP  = 3'd5;
  logic [2:0] state;
  logic       rd_last;
  logic       gw, gr;
  // rd_last set means the read channel won last, so write wins a tie
  assign gw      = (state == IDLE) && awvalid && (!arvalid || rd_last);
  assign gr      = (state == IDLE) && arvalid && !gw;
  assign awready = gw;
  assign arready = gr;
  assign wready  = state == WDATA;
  assign psel    = (state == SETUP) || (state == ACCESS);
  assign penable = state == ACCESS;
  assign bvalid  = state == BRESP;
  assign rvalid  = state == RRESP;
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state   <= IDLE;
      rd_last <= 1'b1;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pprot   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
      rdata   <= '0;
      bresp   <= '0;
      rresp   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gw) begin
            paddr   <= awaddr;
            pprot   <= awprot;
            pwrite  <= 1'b1;
            rd_last <= 1'b0;
            state   <= WDATA;
          end else if (gr) begin
            paddr   <= araddr;
            pprot   <= arprot;
            pwrite  <= 1'b0;
            pstrb   <= '0;
            rd_last <= 1'b1;
            state   <= SETUP;
          end
        end
        WDATA: begin
          if (wvalid) begin
            pwdata <= wdata;
            pstrb  <= wstrb;
            state  <= SETUP;
          end
        end
        SETUP: state <= ACCESS;
        ACCESS: begin
          if (pready) begin
            if (pwrite) bresp <= pslverr ? 2'b10 : 2'b00;
            else begin
              rresp <= pslverr ? 2'b10 : 2'b00;
              rdata <= prdata;
            end
            state <= pwrite ? BRESP : RRESP;
          end
        end
        BRESP: state <= bready ? IDLE : BRESP;
        RRESP: state <= rready ? IDLE : RRESP;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_apb_master.sv
// tb_axil_apb_master: directed and randomized transactions against a transaction-level model of the bridge
module tb_axil_apb_master;
  logic        aclk = 0, aresetn = 0;
  logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata, paddr, pwdata, prdata = 0;
  logic [2:0]  awprot = 0, arprot = 0, pprot;
  logic [3:0]  wstrb = 0, pstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid = 0, arready, rvalid, rready = 0;
  logic        psel, penable, pwrite, pready = 0, pslverr = 0;
  int          vectors = 0, miscompares = 0;
  logic [1:0]  m_bresp = 0, m_rresp = 0;
  logic [31:0] m_rdata = 0;

  axil_apb_master #(.dataWidth(32), .addrWidth(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pprot(pprot),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset;
    aresetn = 0;
    tick();
    tick();
    aresetn = 1;
    m_bresp = 0;
    m_rresp = 0;
    m_rdata = 0;
  endtask

  task automatic chk_reset_vals;
    chk("rst_psel", psel, 0);       chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);   chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);   chk("rst_rvalid", rvalid, 0);
    chk("rst_awready", awready, 0); chk("rst_arready", arready, 0);
    chk("rst_paddr", paddr, 0);     chk("rst_pprot", pprot, 0);
    chk("rst_pwdata", pwdata, 0);   chk("rst_pstrb", pstrb, 0);
    chk("rst_rdata", rdata, 0);     chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [2:0] p, input int waits, input logic err, input int bdly);
    int n = 0;
    awvalid = 1; awaddr = a; awprot = p;
    #1;
    while (!awready && n < 20) begin tick(); n++; end
    chk("w_awready", awready, 1);
    tick();
    awvalid = 0;
    chk("w_wready", wready, 1);
    chk("w_psel_wdata", psel, 0);
    wvalid = 1; wdata = d; wstrb = s;
    tick();
    wvalid = 0; wdata = $urandom;
    chk("w_setup_psel", psel, 1);   chk("w_setup_penable", penable, 0);
    chk("w_pwrite", pwrite, 1);     chk("w_paddr", paddr, a);
    chk("w_pwdata", pwdata, d);     chk("w_pstrb", pstrb, s);
    chk("w_pprot", pprot, p);       chk("w_setup_wready", wready, 0);
    tick();
    for (int i = 0; i < waits; i++) begin
      pready = 0;
      chk("w_acc_penable", penable, 1); chk("w_acc_paddr", paddr, a);
      chk("w_acc_pwdata", pwdata, d);   chk("w_acc_pstrb", pstrb, s);
      tick();
    end
    chk("w_last_penable", penable, 1);
    pready = 1; pslverr = err;
    tick();
    pready = 0; pslverr = 0;
    m_bresp = err ? 2'b10 : 2'b00;
    chk("w_bvalid", bvalid, 1);
    chk("w_resp_psel", psel, 0);
    chk("w_resp_penable", penable, 0);
    chk("w_bresp", bresp, m_bresp);
    for (int i = 0; i < bdly; i++) begin
      tick();
      chk("w_bvalid_hold", bvalid, 1);
      chk("w_bresp_hold", bresp, m_bresp);
    end
    bready = 1;
    tick();
    bready = 0;
    chk("w_bvalid_done", bvalid, 0);
    chk("w_bresp_after", bresp, m_bresp);
    chk("w_rresp_kept", rresp, m_rresp);
    chk("w_rdata_kept", rdata, m_rdata);
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] d, input logic [2:0] p,
                          input int waits, input logic err, input int rdly);
    int n = 0;
    arvalid = 1; araddr = a; arprot = p;
    #1;
    while (!arready && n < 20) begin tick(); n++; end
    chk("r_arready", arready, 1);
    tick();
    arvalid = 0;
    chk("r_setup_psel", psel, 1);   chk("r_setup_penable", penable, 0);
    chk("r_pwrite", pwrite, 0);     chk("r_paddr", paddr, a);
    chk("r_pprot", pprot, p);       chk("r_pstrb", pstrb, 0);
    chk("r_wready", wready, 0);
    tick();
    for (int i = 0; i < waits; i++) begin
      pready = 0; pslverr = 1; prdata = $urandom;
      chk("r_acc_penable", penable, 1); chk("r_acc_paddr", paddr, a);
      tick();
    end
    chk("r_last_penable", penable, 1);
    pready = 1; pslverr = err; prdata = d;
    tick();
    pready = 0; pslverr = 0; prdata = $urandom;
    m_rresp = err ? 2'b10 : 2'b00;
    m_rdata = d;
    chk("r_rvalid", rvalid, 1);
    chk("r_resp_psel", psel, 0);
    chk("r_rdata", rdata, m_rdata);
    chk("r_rresp", rresp, m_rresp);
    for (int i = 0; i < rdly; i++) begin
      tick();
      chk("r_rvalid_hold", rvalid, 1);
      chk("r_rdata_hold", rdata, m_rdata);
    end
    rready = 1;
    tick();
    rready = 0;
    chk("r_rvalid_done", rvalid, 0);
    chk("r_rdata_after", rdata, m_rdata);
    chk("r_bresp_kept", bresp, m_bresp);
    chk("r_rresp_after", rresp, m_rresp);
  endtask

  initial begin
    int g, n;
    logic exp_w;
    do_reset();
    chk_reset_vals();
    // write, all ready, followed by read with three wait states
    axi_write(32'h1000, 32'hDEADBEEF, 4'hF, 3'd0, 0, 0, 0);
    axi_read(32'h2004, 32'hA5A5A5A5, 3'd2, 3, 0, 0);
    // slave error on write must not leak into the read response
    axi_write(32'h3000, 32'h12345678, 4'h3, 3'd1, 1, 1, 0);
    axi_read(32'h3004, 32'h0BADF00D, 3'd0, 0, 0, 1);
    // write response backpressure
    axi_write(32'h4000, 32'hCAFEBABE, 4'h8, 3'd7, 2, 0, 5);
    // early wvalid must wait for the address handshake
    wvalid = 1; wdata = 32'h55AA55AA; wstrb = 4'h5;
    for (int i = 0; i < 3; i++) begin tick(); chk("early_wready", wready, 0); end
    wvalid = 0;
    axi_write(32'h5000, 32'h55AA55AA, 4'h5, 3'd3, 0, 0, 0);
    // reset during ACCESS abandons the transaction
    awvalid = 1; awaddr = 32'h6000; awprot = 3'd5;
    tick();
    awvalid = 0; wvalid = 1; wdata = 32'hFFFF0000; wstrb = 4'hF;
    tick();
    wvalid = 0;
    tick();
    chk("mid_penable", penable, 1);
    chk("mid_paddr", paddr, 32'h6000);
    aresetn = 0;
    tick();
    chk("mid_rst_psel", psel, 0);
    chk("mid_rst_penable", penable, 0);
    chk("mid_rst_bvalid", bvalid, 0);
    aresetn = 1;
    m_bresp = 0; m_rresp = 0; m_rdata = 0;
    chk_reset_vals();
    pready = 1;
    for (int i = 0; i < 3; i++) begin tick(); chk("mid_no_bvalid", bvalid, 0); chk("mid_no_psel", psel, 0); end
    pready = 0;
    // simultaneous requests alternate, write first after reset
    awvalid = 1; arvalid = 1; wvalid = 1; pready = 1; bready = 1; rready = 1;
    awaddr = 32'h7000; araddr = 32'h7004;
    #1;
    g = 0; n = 0; exp_w = 1;
    while (g < 4 && n < 60) begin
      if (awready || arready) begin
        chk("arb_exclusive", awready & arready, 0);
        chk($sformatf("arb_grant%0d_is_write", g), awready, exp_w);
        exp_w = !exp_w;
        g++;
      end
      tick();
      n++;
    end
    chk("arb_grants_seen", g, 4);
    awvalid = 0; arvalid = 0; wvalid = 0; pready = 0; bready = 0; rready = 0;
    do_reset();
    chk_reset_vals();
    // randomized traffic against the transaction model
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1)
        axi_write($urandom, $urandom, 4'($urandom), 3'($urandom), $urandom_range(0, 3),
                  1'($urandom), $urandom_range(0, 3));
      else
        axi_read($urandom, $urandom, 3'($urandom), $urandom_range(0, 3),
                 1'($urandom), $urandom_range(0, 3));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axil_apb_master.md
AXIL_APB_MASTER -- requirements
Module: axil_apb_master

Interface
REQ-001 SHALL have parameter dataWidth, default 32, meaning AXI-Lite/APB data width in bits (multiple of 8).
REQ-002 SHALL have parameter addrWidth, default 32, meaning AXI-Lite/APB address width in bits.
REQ-003 SHALL use one clock and a synchronous, active-low reset: aclk  in  1  clock, all logic on rising edge; aresetn  in  1  reset, sampled only on the aclk rising edge.
REQ-004 AXI-Lite write ports: awvalid in 1; awready out 1; awaddr in addrWidth; awprot in 3; wvalid in 1; wready out 1; wdata in dataWidth; wstrb in dataWidth/8; bvalid out 1; bready in 1; bresp out 2.
REQ-005 AXI-Lite read ports: arvalid in 1; arready out 1; araddr in addrWidth; arprot in 3; rvalid out 1; rready in 1; rdata out dataWidth; rresp out 2.
REQ-006 APB ports: psel out 1; penable out 1; pwrite out 1; paddr out addrWidth; pprot out 3; pwdata out dataWidth; pstrb out dataWidth/8; pready in 1; prdata in dataWidth; pslverr in 1.

Function
REQ-007 SHALL implement states IDLE, WDATA, SETUP, ACCESS, BRESP, RRESP; all outputs registered or decoded from registered state only.
REQ-008 IDLE: arbitration SHALL be round-robin; the first grant after reset goes to write; on simultaneous awvalid and arvalid, the channel not granted last wins.
REQ-009 IDLE, write granted: awready=1 while awvalid=1; on handshake, awaddr/awprot SHALL be latched into paddr/pprot, pwrite set to 1, and the FSM moves to WDATA.
REQ-010 IDLE, read granted: arready=1 while arvalid=1; on handshake, araddr/arprot SHALL be latched into paddr/pprot, pwrite set to 0, pstrb set to 0, and the FSM moves to SETUP.
REQ-011 wready SHALL be 1 only in WDATA; a wvalid arriving before the aw handshake SHALL wait.
REQ-012 On the WDATA w handshake, wdata/wstrb SHALL be latched into pwdata/pstrb and the FSM moves to SETUP.
REQ-013 SETUP: psel=1 and penable=0 for exactly one cycle, then move to ACCESS.
REQ-014 ACCESS: psel=1 and penable=1; stay while pready=0; paddr, pwrite, pwdata, pstrb and pprot SHALL stay stable from SETUP through ACCESS completion.
REQ-015 ACCESS with pready=1: resp SHALL be 2'b10 (SLVERR) if pslverr=1, else 2'b00 (OKAY); read captures prdata into rdata; the FSM moves to BRESP for a write or RRESP for a read, and psel/penable drop to 0 next cycle.
REQ-016 BRESP: bvalid=1 with bresp held stable until bready=1; then return to IDLE.
REQ-017 RRESP: rvalid=1 with rdata/rresp held stable until rready=1; then return to IDLE.
REQ-018 SHALL allow only one transaction in flight; awready/arready SHALL be 0 outside IDLE.
REQ-019 Minimum latency with all ready signals high: write, aw handshake at cycle 0 -> w cycle 1 -> SETUP 2 -> ACCESS 3 -> bvalid cycle 4; read, ar handshake at cycle 0 -> SETUP 1 -> ACCESS 2 -> rvalid cycle 3.
REQ-020 pready SHALL be ignored outside ACCESS, and bready/rready outside their response states.
REQ-021 rdata SHALL hold its last captured value outside RRESP; bresp/rresp SHALL update only on ACCESS completion of their own transaction type.

Reset
REQ-022 While aresetn=0 at a rising edge, the FSM SHALL go to IDLE with round-robin pointer at write-first; psel, penable, pwrite, awready, wready, arready, bvalid and rvalid SHALL be 0; paddr, pprot, pwdata, pstrb, rdata, bresp and rresp SHALL be all-zero.
REQ-023 Reset asserted mid-transaction, including during ACCESS, SHALL abandon the transaction with no AXI response issued; psel/penable SHALL be 0 after the first reset edge.

Verification
REQ-024 Write, all ready: awaddr=0x1000, wdata=0xDEADBEEF, wstrb=0xF, pready=1 -> psel at cycle 2, penable at cycle 3, bvalid at cycle 4, bresp=00.
REQ-025 Read with wait states: araddr=0x2004, pready low for 3 ACCESS cycles, prdata=0xA5A5A5A5 -> ACCESS lasts 4 cycles, paddr stable throughout, then rdata=0xA5A5A5A5, rresp=00, pstrb=0.
REQ-026 Error: write with pslverr=1 at pready -> bresp=10; then a read with pslverr=0 -> rresp=00, and bresp remains 10.
REQ-027 Arbitration: awvalid and arvalid high together continuously after reset -> order W, R, W, R; wvalid asserted before awvalid -> wready stays low until WDATA.
REQ-028 Backpressure and reset: bready held low 5 cycles -> bvalid and bresp stable; aresetn=0 during ACCESS -> next cycle psel=0, penable=0, state IDLE, no bvalid.
